// File: rtl/mult_sched_pkg.sv
// Shared types and defaults for the round-robin multiplier scheduler.
//   sched_state_e : scheduler FSM states (IDLE, ISSUE, WAIT, RESP)
//   DefABits / DefBBits / DefPBits : default operand and product widths
//   StatW : width of each statistics counter
package mult_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } sched_state_e;

  localparam int unsigned DefABits = 130;
  localparam int unsigned DefBBits = 128;
  localparam int unsigned DefPBits = 258;
  localparam int unsigned StatW    = 16;

endpackage

// File: rtl/mult_rr_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester set in req, searching from
// ptr upwards with wrap-around. Purely combinational.
// Ports:
//   req       : per-requester request bits
//   ptr       : index where the search starts
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester (0 when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IdxW-1:0] grant_idx
);

  logic            w_found;
  logic [IdxW-1:0] w_idx;

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] p,
                                               input int unsigned off);
    return IdxW'((32'(p) + off) % NREQ);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = wrap_idx(ptr, off);
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        grant_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin scheduler in front of a shared limb multiplier. Serves one
// multiplication at a time: grant, issue to the multiplier, wait for the
// result, present it on the response channel until accepted.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_valid / req_ready   : per-requester handshake (ready is one-hot)
//   req_a / req_b           : flattened operands, requester k at [k*W +: W]
//   mult_start/_a/_b        : issue to multiplier (operands held until next grant)
//   mult_busy/_done/_product: multiplier status and result
//   rsp_valid/_ready/_id/_product : result channel
// Optional build macro MULT_SCHED_STATS_EN adds:
//   stat_issue_cnt : per-requester grant counters (16 bits each, saturating)
//   stat_stall_cnt : RESP cycles with rsp_ready low (saturating)
module mult_rr_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned A_BITS = DefABits,
  parameter int unsigned B_BITS = DefBBits,
  parameter int unsigned P_BITS = DefPBits,
  parameter int unsigned ID_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*A_BITS-1:0] req_a,
  input  logic [NREQ*B_BITS-1:0] req_b,
  output logic                   mult_start,
  output logic [A_BITS-1:0]      mult_a,
  output logic [B_BITS-1:0]      mult_b,
  input  logic                   mult_busy,
  input  logic                   mult_done,
  input  logic [P_BITS-1:0]      mult_product,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [P_BITS-1:0]      rsp_product
`ifdef MULT_SCHED_STATS_EN
  ,
  output logic [NREQ*StatW-1:0]  stat_issue_cnt,
  output logic [StatW-1:0]       stat_stall_cnt
`endif
);

  sched_state_e        r_state, w_state_d;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_job_id;
  logic [A_BITS-1:0]   r_mult_a;
  logic [B_BITS-1:0]   r_mult_b;
  logic [ID_W-1:0]     r_rsp_id;
  logic [P_BITS-1:0]   r_rsp_product;

  logic [NREQ-1:0]     w_grant;
  logic [ID_W-1:0]     w_grant_idx;
  logic                w_any;
  logic                w_accept;
  logic [A_BITS-1:0]   w_sel_a;
  logic [B_BITS-1:0]   w_sel_b;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign w_any = |w_grant;

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a = req_a[k*A_BITS +: A_BITS];
        w_sel_b = req_b[k*B_BITS +: B_BITS];
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    req_ready  = '0;
    mult_start = 1'b0;
    w_accept   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          req_ready = w_grant;
          w_accept  = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue: begin
        if (!mult_busy) begin
          mult_start = 1'b1;
          w_state_d  = StWait;
        end
      end
      StWait: begin
        if (mult_done) w_state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // Combinational outputs must read zero while reset is held, even before
    // the first reset edge has cleared the state register.
    if (reset) begin
      req_ready  = '0;
      mult_start = 1'b0;
      w_accept   = 1'b0;
      w_state_d  = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_rr_ptr      <= '0;
      r_job_id      <= '0;
      r_mult_a      <= '0;
      r_mult_b      <= '0;
      r_rsp_id      <= '0;
      r_rsp_product <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_rr_ptr <= (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
        r_job_id <= w_grant_idx;
        r_mult_a <= w_sel_a;
        r_mult_b <= w_sel_b;
      end
      // Done pulses outside WAIT are dropped here.
      if (r_state == StWait && mult_done) begin
        r_rsp_product <= mult_product;
        r_rsp_id      <= r_job_id;
      end
    end
  end

  assign mult_a      = r_mult_a;
  assign mult_b      = r_mult_b;
  assign rsp_valid   = (r_state == StResp) && !reset;
  assign rsp_id      = r_rsp_id;
  assign rsp_product = r_rsp_product;

`ifdef MULT_SCHED_STATS_EN
  logic [StatW-1:0] r_issue_cnt [NREQ];
  logic [StatW-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NREQ; k++) r_issue_cnt[k] <= '0;
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (w_accept && w_grant[k] && (r_issue_cnt[k] != '1)) begin
          r_issue_cnt[k] <= r_issue_cnt[k] + 1'b1;
        end
      end
      if ((r_state == StResp) && !rsp_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREQ; k++) begin : g_stat
    assign stat_issue_cnt[k*StatW +: StatW] = r_issue_cnt[k];
  end
  assign stat_stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mult_rr_sched.sv
// Self-checking bench for mult_rr_sched with a behavioural multiplier model.
module tb_mult_rr_sched;
  import mult_sched_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned A    = DefABits;
  localparam int unsigned B    = DefBBits;
  localparam int unsigned P    = DefPBits;
  localparam int unsigned ID_W = 2;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*A-1:0]   req_a;
  logic [NREQ*B-1:0]   req_b;
  logic                mult_start;
  logic [A-1:0]        mult_a;
  logic [B-1:0]        mult_b;
  logic                mult_busy;
  logic                mult_done;
  logic [P-1:0]        mult_product;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [P-1:0]        rsp_product;
`ifdef MULT_SCHED_STATS_EN
  logic [NREQ*StatW-1:0] stat_issue_cnt;
  logic [StatW-1:0]      stat_stall_cnt;
`endif

  mult_rr_sched #(
    .NREQ   (NREQ),
    .A_BITS (A),
    .B_BITS (B),
    .P_BITS (P),
    .ID_W   (ID_W)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_busy    (mult_busy),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product)
`ifdef MULT_SCHED_STATS_EN
    ,
    .stat_issue_cnt (stat_issue_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Requester operand store, mirrored onto the flattened buses.
  logic [A-1:0] op_a [NREQ];
  logic [B-1:0] op_b [NREQ];

  task automatic set_op(input int k, input logic [A-1:0] a, input logic [B-1:0] b);
    op_a[k] = a;
    op_b[k] = b;
    req_a[k*A +: A] = a;
    req_b[k*B +: B] = b;
  endtask

  // Behavioural multiplier: busy for lat cycles after a start, then one done pulse.
  logic         m_busy, m_done, force_busy, spur_done;
  logic         nx_busy, nx_done;
  logic [P-1:0] m_prod, nx_prod;
  logic [A-1:0] m_a;
  logic [B-1:0] m_b;
  int           m_cnt;
  int           lat;

  assign mult_busy    = m_busy | force_busy;
  assign mult_done    = m_done | spur_done;
  assign mult_product = m_prod;

  initial begin
    m_busy = 1'b0; m_done = 1'b0; m_prod = '0; m_cnt = 0; m_a = '0; m_b = '0;
    forever begin
      @(negedge clk);
      nx_done = 1'b0;
      nx_busy = m_busy;
      nx_prod = m_prod;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          nx_busy = 1'b0;
          nx_done = 1'b1;
          nx_prod = P'(m_a) * P'(m_b);
        end
      end else if (mult_start) begin
        m_a = mult_a;
        m_b = mult_b;
        m_cnt = lat;
        nx_busy = 1'b1;
      end
      @(posedge clk);
      #1;
      m_busy = nx_busy;
      m_done = nx_done;
      m_prod = nx_prod;
    end
  end

  // Reference scoreboard: round-robin grant prediction and expected responses.
  typedef struct {
    logic [ID_W-1:0] id;
    logic [P-1:0]    prod;
  } exp_t;
  exp_t            exp_q[$];
  exp_t            mon_e;
  int              ref_ptr;
  int              mon_g;
  logic [NREQ-1:0] mon_eg;
  bit              acc_seen [NREQ];

  initial begin
    ref_ptr = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        ref_ptr = 0;
      end else begin
        if (req_ready != '0) begin
          mon_g = -1;
          for (int j = 0; j < NREQ; j++) begin
            if (mon_g < 0 && req_valid[(ref_ptr + j) % NREQ]) mon_g = (ref_ptr + j) % NREQ;
          end
          mon_eg = '0;
          if (mon_g >= 0) mon_eg[mon_g] = 1'b1;
          chk("grant", P'(req_ready), P'(mon_eg));
          if (mon_g >= 0) begin
            mon_e.id   = ID_W'(mon_g);
            mon_e.prod = P'(op_a[mon_g]) * P'(op_b[mon_g]);
            exp_q.push_back(mon_e);
            ref_ptr = (mon_g + 1) % NREQ;
            acc_seen[mon_g] = 1'b1;
          end
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got id %0d, required no response", rsp_id);
          end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_id", P'(rsp_id), P'(mon_e.id));
            chk("rsp_product", rsp_product, mon_e.prod);
          end
        end
      end
    end
  end

  // Bounded wait at negedges: 0 ready, 1 rsp_valid, 2 mult_start, 3 drained.
  task automatic wait_cond(input int sel, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = (req_ready != '0);
        1: ok = rsp_valid;
        2: ok = mult_start;
        3: ok = (exp_q.size() == 0) && !rsp_valid && (req_valid == '0);
        default: ok = 1'b0;
      endcase
      if (ok) break;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL timeout_%s: not seen within 200 cycles, required within bound", name);
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] rv;
    logic [A-1:0]    a;
    logic [B-1:0]    b;
    logic [ID_W-1:0] id;
    logic [P-1:0]    prod;
  } vec_t;
  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    bit ok;
    int g;
    g = 0;
    for (int k = 0; k < NREQ; k++) if (v.rv[k]) g = k;
    set_op(g, v.a, v.b);
    req_valid = v.rv;
    wait_cond(0, "vec_ready", ok);
    if (!ok) return;
    chk("vec_ready", P'(req_ready), P'(v.rv));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("vec_start_t1", P'(mult_start), P'(1));
    chk("vec_mult_a", P'(mult_a), P'(v.a));
    chk("vec_mult_b", P'(mult_b), P'(v.b));
    wait_cond(1, "vec_rsp", ok);
    if (ok) begin
      chk("vec_rsp_id", P'(rsp_id), P'(v.id));
      chk("vec_rsp_product", rsp_product, v.prod);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [A-1:0] rand_a();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      default: return A'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    endcase
  endfunction

  function automatic logic [B-1:0] rand_b();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      default: return B'({$urandom(), $urandom(), $urandom(), $urandom()});
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    bit              ok;
    bit              stable;
    int              ord [5];
    logic [NREQ-1:0] eo;
    logic [ID_W-1:0] id0;
    logic [P-1:0]    p0;
    logic [P-1:0]    max_prod;

    max_prod = P'(0) - (P'(1) << 130) - (P'(1) << 128) + P'(1);
    vecs[0] = '{rv: 4'b0001, a: A'(3), b: B'(5), id: 2'd0, prod: P'(15)};
    vecs[1] = '{rv: 4'b0100, a: A'(7), b: B'(11), id: 2'd2, prod: P'(77)};
    vecs[2] = '{rv: 4'b1000, a: {A{1'b1}}, b: {B{1'b1}}, id: 2'd3, prod: max_prod};
    vecs[3] = '{rv: 4'b0010, a: A'(0), b: B'(12345), id: 2'd1, prod: P'(0)};
    ord = '{0, 1, 2, 3, 0};

    reset = 1'b1; req_valid = '1; rsp_ready = 1'b1; lat = 3;
    force_busy = 1'b0; spur_done = 1'b0; req_a = '0; req_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = '0; op_b[k] = '0; acc_seen[k] = 1'b0;
    end

    // Reset state, with every requester asserting valid.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", P'(req_ready), P'(0));
    chk("rst_mult_start", P'(mult_start), P'(0));
    chk("rst_rsp_valid", P'(rsp_valid), P'(0));
    chk("rst_rsp_id", P'(rsp_id), P'(0));
    chk("rst_rsp_product", rsp_product, P'(0));
    chk("rst_mult_a", P'(mult_a), P'(0));
    chk("rst_mult_b", P'(mult_b), P'(0));
`ifdef MULT_SCHED_STATS_EN
    chk("rst_stall_cnt", P'(stat_stall_cnt), P'(0));
    chk("rst_issue_cnt", P'(stat_issue_cnt), P'(0));
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = '0;

    // All requesters held: grants rotate 0,1,2,3 and wrap back to 0.
    for (int k = 0; k < NREQ; k++) set_op(k, A'(k + 1), B'(k + 10));
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_cond(0, "rr_ready", ok);
      eo = '0;
      eo[ord[i]] = 1'b1;
      chk("rr_order", P'(req_ready), P'(eo));
      @(posedge clk); #1;
      set_op(ord[i], A'(100 + i), B'(200 + i));
      if (i == 4) req_valid = '0;
    end
    wait_cond(3, "rr_drain", ok);
    @(posedge clk); #1;

    // Directed single-requester vectors.
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Response stall for 10 cycles with another requester waiting.
    rsp_ready = 1'b0;
    set_op(0, A'(21), B'(2));
    req_valid = 4'b0001;
    wait_cond(0, "stall_ready", ok);
    @(posedge clk); #1;
    req_valid = '0;
    set_op(1, A'(6), B'(7));
    req_valid = 4'b0010;
    wait_cond(1, "stall_rsp", ok);
    id0 = rsp_id;
    p0  = rsp_product;
    chk("stall_rsp_id", P'(id0), P'(0));
    chk("stall_rsp_product", p0, P'(42));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (!(rsp_valid && rsp_id == id0 && rsp_product == p0 && req_ready == '0)) stable = 1'b0;
    end
    chk("stall_stable", P'(stable), P'(1));
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("handshake_rsp_valid", P'(rsp_valid), P'(1));
    chk("handshake_no_ready", P'(req_ready), P'(0));
    @(negedge clk);
    chk("bubble_grant", P'(req_ready), P'(4'b0010));
    chk("bubble_rsp_valid", P'(rsp_valid), P'(0));
`ifdef MULT_SCHED_STATS_EN
    chk("stall_cnt", P'(stat_stall_cnt), P'(10));
`endif
    @(posedge clk); #1;
    req_valid = '0;
    wait_cond(3, "stall_drain", ok);
`ifdef MULT_SCHED_STATS_EN
    chk("issue_cnt0", P'(stat_issue_cnt[0 +: 16]), P'(4));
    chk("issue_cnt1", P'(stat_issue_cnt[16 +: 16]), P'(3));
    chk("issue_cnt2", P'(stat_issue_cnt[32 +: 16]), P'(2));
    chk("issue_cnt3", P'(stat_issue_cnt[48 +: 16]), P'(2));
`endif
    @(posedge clk); #1;

    // Multiplier busy for 5 cycles in ISSUE delays the start by 5 cycles.
    force_busy = 1'b1;
    set_op(3, A'(4), B'(4));
    req_valid = 4'b1000;
    wait_cond(0, "busy_ready", ok);
    @(posedge clk); #1;
    req_valid = '0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mult_start) stable = 1'b0;
    end
    chk("busy_no_start", P'(stable), P'(1));
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
    chk("start_after_busy", P'(mult_start), P'(1));
    wait_cond(3, "busy_drain", ok);
    @(posedge clk); #1;

    // Spurious done while idle produces no response.
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) stable = 1'b0;
    end
    chk("spurious_no_rsp", P'(stable), P'(1));
    @(posedge clk); #1;

    // Reset during WAIT aborts the job; the next request is served normally.
    set_op(2, A'(1000), B'(1000));
    req_valid = 4'b0100;
    wait_cond(0, "rstw_ready", ok);
    @(posedge clk); #1;
    req_valid = '0;
    wait_cond(2, "rstw_start", ok);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_req_ready", P'(req_ready), P'(0));
    chk("rstw_mult_start", P'(mult_start), P'(0));
    chk("rstw_rsp_valid", P'(rsp_valid), P'(0));
    chk("rstw_rsp_id", P'(rsp_id), P'(0));
    chk("rstw_rsp_product", rsp_product, P'(0));
    chk("rstw_mult_a", P'(mult_a), P'(0));
    chk("rstw_mult_b", P'(mult_b), P'(0));
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) stable = 1'b0;
    end
    chk("rstw_no_rsp", P'(stable), P'(1));
    @(posedge clk); #1;
    run_vec(vecs[0]);

    // Randomised traffic against the scoreboard.
    for (int k = 0; k < NREQ; k++) acc_seen[k] = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(1, 5);
      for (int k = 0; k < NREQ; k++) begin
        if (acc_seen[k]) begin
          acc_seen[k] = 1'b0;
          req_valid[k] = 1'b0;
        end else if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
          set_op(k, rand_a(), rand_b());
          req_valid[k] = 1'b1;
        end
      end
    end
    rsp_ready = 1'b1;
    stable = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc_seen[k]) begin
          acc_seen[k] = 1'b0;
          req_valid[k] = 1'b0;
        end
      end
      if (req_valid == '0 && exp_q.size() == 0 && !rsp_valid) begin
        stable = 1'b1;
        break;
      end
    end
    chk("random_drain", P'(stable), P'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mult_rr_sched.md
MULT_RR_SCHED -- requirements
Module: mult_rr_sched

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; A_BITS, default 130, operand A width; B_BITS, default 128, operand B width; P_BITS, default 258, product width; ID_W, default 2, requester-ID width, clog2(NREQ).
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  NREQ  per-requester operand valid.
REQ-005 req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-006 req_a  input  NREQ*A_BITS  flattened A operands; requester k uses bits [k*A_BITS +: A_BITS].
REQ-007 req_b  input  NREQ*B_BITS  flattened B operands, same layout.
REQ-008 mult_start  output  1  start pulse to the shared limb multiplier.
REQ-009 mult_a / mult_b  output  A_BITS / B_BITS  operands to the multiplier.
REQ-010 mult_busy, mult_done  input  1 each  multiplier status; mult_done is a one-cycle pulse.
REQ-011 mult_product  input  P_BITS  multiplier result, valid in the mult_done cycle.
REQ-012 rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  ID_W, rsp_product  output  P_BITS: result channel.

Function
REQ-013 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and SHALL serve one multiplication at a time.
REQ-014 IDLE: if any req_valid is high, grant round-robin starting at rr_ptr; assert req_ready[grant] for that cycle; latch operands and grant ID; go to ISSUE. If no req_valid is high, stay in IDLE.
REQ-015 rr_ptr SHALL become (grant+1) mod NREQ on each grant; the search order is rr_ptr, rr_ptr+1, ... with wrap-around.
REQ-016 ISSUE: while mult_busy is high, hold. Otherwise drive mult_start high for exactly one cycle and go to WAIT; mult_a and mult_b SHALL hold the latched operands from ISSUE until the next grant.
REQ-017 WAIT: when mult_done is high, capture mult_product and go to RESP; rsp_valid SHALL rise the following cycle.
REQ-018 RESP: rsp_valid is high; rsp_id and rsp_product SHALL stay stable until the rsp_ready handshake, then go to IDLE. New grants resume the cycle after the handshake, a one-cycle bubble.
REQ-019 A mult_done pulse outside WAIT SHALL be ignored.
REQ-020 req_ready SHALL be low in ISSUE, WAIT and RESP. A requester holding req_valid keeps its operands stable until accepted.
REQ-021 Latency from the accept cycle T: mult_start at T+1 (mult_busy low); rsp_valid in the cycle after mult_done.
REQ-022 Width rule: rsp_product SHALL be mult_product unmodified; no truncation or extension.

Reset
REQ-023 While reset is high, the FSM SHALL go to IDLE and rr_ptr to 0, and req_ready, mult_start, rsp_valid, rsp_id, rsp_product, mult_a and mult_b SHALL be 0.
REQ-024 Reset mid-operation SHALL discard the in-flight job without a response. After reset, ISSUE still waits for mult_busy low.

Configuration
REQ-025 With MULT_SCHED_STATS_EN defined, the block SHALL add these outputs, all cleared by reset:
- stat_issue_cnt, NREQ*16 bits: per-requester grant count, saturating at 0xFFFF.
- stat_stall_cnt, 16 bits: RESP cycles with rsp_ready low, saturating at 0xFFFF.
REQ-026 Without MULT_SCHED_STATS_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-027 Package mult_sched_pkg SHALL hold the FSM state enum, A_BITS/B_BITS/P_BITS defaults and the 16-bit stat counter width.
REQ-028 Sub-module rr_arbiter (parameter NREQ; inputs req and ptr; output one-hot grant plus its index) SHALL perform the round-robin search. All other logic SHALL be in mult_rr_sched.

Verification
REQ-029 The bench SHALL cover, with the team limb multiplier (PAR_PER_CYCLE=4) and rsp_ready tied high:
- req_valid=0001, a=3, b=5: req_ready[0] at T, mult_start at T+1, one response with rsp_id=0, rsp_product=15.
- req_valid=1111 held: grants in order 0,1,2,3,0. rr_ptr wraps.
- a=2^130-1, b=2^128-1: rsp_product equals the exact 258-bit product.
REQ-030 The bench SHALL also cover:
- rsp_ready low for 10 cycles in RESP: rsp_valid, rsp_id and rsp_product stay stable, no new req_ready, stat_stall_cnt=10 (STATS_EN).
- mult_busy forced high for 5 cycles in ISSUE: mult_start delayed 5 cycles. A spurious mult_done in IDLE produces no rsp_valid.
- reset pulsed during WAIT: all outputs 0 the next cycle, no response for the aborted job, next request served normally.
